// File: rtl/ddr2_data_path_lanes.sv
// DDR2 data path: write-side DQ/DM/DQS generation with automatic preamble/postamble,
// read-side per-lane whole-cycle deskew, and per-lane saturating IDELAY tap control.
module ddr2_data_path_lanes #(
    parameter int DATA_WIDTH = 16,
    parameter int DQ_PER_DQS = 8,
    parameter int TAP_W      = 6,
    parameter int TAP_MAX    = 63,
    localparam int LANES     = DATA_WIDTH / DQ_PER_DQS
) (
    input  logic                     clk,
    input  logic                     reset0,
    // write side
    input  logic                     wr_en,
    input  logic [DATA_WIDTH-1:0]    wr_data_rise,
    input  logic [DATA_WIDTH-1:0]    wr_data_fall,
    input  logic [LANES-1:0]         mask_data_rise,
    input  logic [LANES-1:0]         mask_data_fall,
    output logic [DATA_WIDTH-1:0]    dq_rise_o,
    output logic [DATA_WIDTH-1:0]    dq_fall_o,
    output logic                     dq_oe,
    output logic [LANES-1:0]         dm_rise_o,
    output logic [LANES-1:0]         dm_fall_o,
    output logic [LANES-1:0]         dqs_rise_o,
    output logic [LANES-1:0]         dqs_fall_o,
    output logic                     dqs_oe,
    output logic                     wr_busy,
    // read side
    input  logic [DATA_WIDTH-1:0]    rd_dq_rise_i,
    input  logic [DATA_WIDTH-1:0]    rd_dq_fall_i,
    input  logic                     rd_en,
    input  logic [2*LANES-1:0]       lane_lat,
    output logic [DATA_WIDTH-1:0]    rd_data_rise,
    output logic [DATA_WIDTH-1:0]    rd_data_fall,
    output logic                     rd_valid,
    // tap control
    input  logic [LANES-1:0]         dly_rst,
    input  logic [LANES-1:0]         dly_ce,
    input  logic [LANES-1:0]         dly_inc,
    output logic [TAP_W*LANES-1:0]   lane_tap,
    output logic [DATA_WIDTH-1:0]    data_idelay_rst,
    output logic [DATA_WIDTH-1:0]    data_idelay_ce,
    output logic [DATA_WIDTH-1:0]    data_idelay_inc
);

    // ---------------- write pipeline ----------------
    logic                  p1_q, p2_q, p3_q;
    logic [DATA_WIDTH-1:0] wr_rise1_q, wr_fall1_q, wr_rise2_q, wr_fall2_q;
    logic [LANES-1:0]      mask_rise1_q, mask_fall1_q, mask_rise2_q, mask_fall2_q;

    always_ff @(posedge clk or posedge reset0) begin
        if (reset0) begin
            p1_q         <= 1'b0;
            p2_q         <= 1'b0;
            p3_q         <= 1'b0;
            wr_rise1_q   <= '0;
            wr_fall1_q   <= '0;
            wr_rise2_q   <= '0;
            wr_fall2_q   <= '0;
            mask_rise1_q <= '0;
            mask_fall1_q <= '0;
            mask_rise2_q <= '0;
            mask_fall2_q <= '0;
        end else begin
            p1_q         <= wr_en;
            p2_q         <= p1_q;
            p3_q         <= p2_q;
            wr_rise1_q   <= wr_data_rise;
            wr_fall1_q   <= wr_data_fall;
            wr_rise2_q   <= wr_rise1_q;
            wr_fall2_q   <= wr_fall1_q;
            mask_rise1_q <= mask_data_rise;
            mask_fall1_q <= mask_data_fall;
            mask_rise2_q <= mask_rise1_q;
            mask_fall2_q <= mask_fall1_q;
        end
    end

    // p1 and p3 around the data stage give the DQS preamble and postamble cycles
    assign dq_oe      = p2_q;
    assign dq_rise_o  = p2_q ? wr_rise2_q : '0;
    assign dq_fall_o  = p2_q ? wr_fall2_q : '0;
    assign dm_rise_o  = p2_q ? mask_rise2_q : '0;
    assign dm_fall_o  = p2_q ? mask_fall2_q : '0;
    assign dqs_oe     = p1_q | p2_q | p3_q;
    assign dqs_rise_o = {LANES{p2_q}};
    assign dqs_fall_o = '0;
    assign wr_busy    = p1_q | p2_q | p3_q;

    // ---------------- read capture and deskew ----------------
    logic [DATA_WIDTH-1:0] cap_rise_q [4];
    logic [DATA_WIDTH-1:0] cap_fall_q [4];
    logic [DATA_WIDTH-1:0] sel_rise, sel_fall;
    logic [DATA_WIDTH-1:0] rd_rise_q, rd_fall_q;
    logic [4:0]            rd_vld_q;

    always_ff @(posedge clk or posedge reset0) begin
        if (reset0) begin
            for (int k = 0; k < 4; k++) begin
                cap_rise_q[k] <= '0;
                cap_fall_q[k] <= '0;
            end
            rd_rise_q <= '0;
            rd_fall_q <= '0;
            rd_vld_q  <= '0;
        end else begin
            cap_rise_q[0] <= rd_dq_rise_i;
            cap_fall_q[0] <= rd_dq_fall_i;
            for (int k = 1; k < 4; k++) begin
                cap_rise_q[k] <= cap_rise_q[k-1];
                cap_fall_q[k] <= cap_fall_q[k-1];
            end
            rd_rise_q <= sel_rise;
            rd_fall_q <= sel_fall;
            rd_vld_q  <= {rd_vld_q[3:0], rd_en};
        end
    end

    assign rd_data_rise = rd_rise_q;
    assign rd_data_fall = rd_fall_q;
    assign rd_valid     = rd_vld_q[4];

    // ---------------- per-lane deskew select and tap control ----------------
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [1:0]       lat;
            logic [TAP_W-1:0] tap_q, tap_d;
            logic             ce_q, ce_d, rst_q, inc_q;

            // a lane arriving lat cycles late has travelled lat fewer stages
            assign lat = lane_lat[2*gi +: 2];
            assign sel_rise[gi*DQ_PER_DQS +: DQ_PER_DQS] =
                cap_rise_q[2'd3 - lat][gi*DQ_PER_DQS +: DQ_PER_DQS];
            assign sel_fall[gi*DQ_PER_DQS +: DQ_PER_DQS] =
                cap_fall_q[2'd3 - lat][gi*DQ_PER_DQS +: DQ_PER_DQS];

            always_comb begin
                tap_d = tap_q;
                ce_d  = 1'b0;
                if (dly_rst[gi]) begin
                    tap_d = '0;
                end else if (dly_ce[gi] && dly_inc[gi] && (tap_q < TAP_W'(TAP_MAX))) begin
                    tap_d = tap_q + TAP_W'(1);
                    ce_d  = 1'b1;
                end else if (dly_ce[gi] && !dly_inc[gi] && (tap_q != '0)) begin
                    tap_d = tap_q - TAP_W'(1);
                    ce_d  = 1'b1;
                end
            end

            always_ff @(posedge clk or posedge reset0) begin
                if (reset0) begin
                    tap_q <= '0;
                    ce_q  <= 1'b0;
                    rst_q <= 1'b0;
                    inc_q <= 1'b0;
                end else begin
                    tap_q <= tap_d;
                    ce_q  <= ce_d;
                    rst_q <= dly_rst[gi];
                    inc_q <= dly_inc[gi] & dly_ce[gi];
                end
            end

            assign lane_tap[gi*TAP_W +: TAP_W]                    = tap_q;
            assign data_idelay_rst[gi*DQ_PER_DQS +: DQ_PER_DQS]   = {DQ_PER_DQS{rst_q}};
            assign data_idelay_ce[gi*DQ_PER_DQS +: DQ_PER_DQS]    = {DQ_PER_DQS{ce_q}};
            assign data_idelay_inc[gi*DQ_PER_DQS +: DQ_PER_DQS]   = {DQ_PER_DQS{inc_q}};
        end
    endgenerate

endmodule

// File: tb/tb_ddr2_data_path_lanes.sv
// Scoreboard bench for ddr2_data_path_lanes: write beats and read beats are queued at
// issue time and popped when the DUT presents them; tap counters follow a small model.
module tb_ddr2_data_path_lanes;
    localparam int DW = 16, DQ = 8, L = 2, TW = 6, TMAX = 63, NCYC = 4096;

    logic            clk, reset0;
    logic            wr_en, rd_en, dq_oe, dqs_oe, wr_busy, rd_valid;
    logic [DW-1:0]   wr_data_rise, wr_data_fall, dq_rise_o, dq_fall_o;
    logic [L-1:0]    mask_data_rise, mask_data_fall, dm_rise_o, dm_fall_o;
    logic [L-1:0]    dqs_rise_o, dqs_fall_o, dly_rst, dly_ce, dly_inc;
    logic [DW-1:0]   rd_dq_rise_i, rd_dq_fall_i, rd_data_rise, rd_data_fall;
    logic [2*L-1:0]  lane_lat;
    logic [TW*L-1:0] lane_tap;
    logic [DW-1:0]   data_idelay_rst, data_idelay_ce, data_idelay_inc;

    ddr2_data_path_lanes #(.DATA_WIDTH(DW), .DQ_PER_DQS(DQ), .TAP_W(TW), .TAP_MAX(TMAX)) dut (
        .clk(clk), .reset0(reset0), .wr_en(wr_en),
        .wr_data_rise(wr_data_rise), .wr_data_fall(wr_data_fall),
        .mask_data_rise(mask_data_rise), .mask_data_fall(mask_data_fall),
        .dq_rise_o(dq_rise_o), .dq_fall_o(dq_fall_o), .dq_oe(dq_oe),
        .dm_rise_o(dm_rise_o), .dm_fall_o(dm_fall_o),
        .dqs_rise_o(dqs_rise_o), .dqs_fall_o(dqs_fall_o), .dqs_oe(dqs_oe), .wr_busy(wr_busy),
        .rd_dq_rise_i(rd_dq_rise_i), .rd_dq_fall_i(rd_dq_fall_i), .rd_en(rd_en),
        .lane_lat(lane_lat), .rd_data_rise(rd_data_rise), .rd_data_fall(rd_data_fall),
        .rd_valid(rd_valid), .dly_rst(dly_rst), .dly_ce(dly_ce), .dly_inc(dly_inc),
        .lane_tap(lane_tap), .data_idelay_rst(data_idelay_rst),
        .data_idelay_ce(data_idelay_ce), .data_idelay_inc(data_idelay_inc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [DW-1:0] r; logic [DW-1:0] f; logic [L-1:0] mr; logic [L-1:0] mf; } wr_t;
    typedef struct { int due; logic [DW-1:0] r; logic [DW-1:0] f; } rd_t;

    int  checks = 0, errors = 0, cyc = -1, hist_base = 0;
    int  ce_hi_cnt = 0, ce_lo_cnt = 0;
    bit  wr_hist [NCYC];
    logic [DW-1:0] pad_r [NCYC];
    logic [DW-1:0] pad_f [NCYC];
    wr_t wq[$];
    rd_t rq[$];
    int  m_tap [L];
    bit  m_ce [L], m_rst [L], m_inc [L];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic bit wh(input int i);
        return (i < 0 || i < hist_base) ? 1'b0 : wr_hist[i];
    endfunction

    // one call drives the inputs of one clock cycle and records the expected responses
    task automatic drive(input bit we, input logic [DW-1:0] r, input logic [DW-1:0] f,
                         input logic [L-1:0] mr, input logic [L-1:0] mf, input bit re,
                         input logic [L-1:0] drst, input logic [L-1:0] dce, input logic [L-1:0] dinc);
        @(posedge clk);
        #1;
        reset0 = 1'b0;
        cyc++;
        wr_en = we; wr_data_rise = r; wr_data_fall = f;
        mask_data_rise = mr; mask_data_fall = mf;
        rd_en = re; rd_dq_rise_i = pad_r[cyc]; rd_dq_fall_i = pad_f[cyc];
        dly_rst = drst; dly_ce = dce; dly_inc = dinc;
        wr_hist[cyc] = we;
        if (we) wq.push_back('{r, f, mr, mf});
        if (re) begin
            rd_t e;
            int  lat;
            e.due = cyc + 5; e.r = '0; e.f = '0;
            for (int l = 0; l < L; l++) begin
                lat = int'(lane_lat[2*l +: 2]);
                e.r[l*DQ +: DQ] = pad_r[cyc + lat][l*DQ +: DQ];
                e.f[l*DQ +: DQ] = pad_f[cyc + lat][l*DQ +: DQ];
            end
            rq.push_back(e);
        end
    endtask

    task automatic rnd_idle(input int n);
        for (int i = 0; i < n; i++)
            drive(1'b0, DW'($urandom), DW'($urandom), L'($urandom), L'($urandom), 1'b0, '0, '0, '0);
    endtask

    task automatic rnd_cycle();
        logic [L-1:0] drst;
        drst = (($urandom % 16) == 0) ? L'($urandom) : '0;
        drive(1'($urandom), DW'($urandom), DW'($urandom), L'($urandom), L'($urandom),
              (($urandom % 10) < 3), drst, L'($urandom), L'($urandom));
    endtask

    // monitor: checks the cycle whose inputs were driven just after the previous rising edge
    always @(negedge clk) begin
        logic eoe, edqs;
        wr_t  w;
        rd_t  e;
        bit   cr, cc, ci;
        if (reset0) begin
            for (int l = 0; l < L; l++) begin
                m_tap[l] = 0; m_ce[l] = 0; m_rst[l] = 0; m_inc[l] = 0;
            end
        end else if (cyc >= 0) begin
            eoe  = wh(cyc - 2);
            edqs = wh(cyc - 1) | wh(cyc - 2) | wh(cyc - 3);
            chk("dq_oe", 64'(dq_oe), 64'(eoe));
            chk("dqs_oe", 64'(dqs_oe), 64'(edqs));
            chk("wr_busy", 64'(wr_busy), 64'(edqs));
            chk("dqs_rise", 64'(dqs_rise_o), 64'({L{eoe}}));
            chk("dqs_fall", 64'(dqs_fall_o), 64'(0));
            if (dq_oe) begin
                if (wq.size() == 0) begin
                    chk("wr_unexpected", 64'(1), 64'(0));
                end else begin
                    w = wq.pop_front();
                    chk("dq_data", {dq_rise_o, dq_fall_o, dm_rise_o, dm_fall_o},
                        {w.r, w.f, w.mr, w.mf});
                    $display("WR cyc=%0d dq_rise=%h dq_fall=%h dm=%b/%b",
                             cyc, dq_rise_o, dq_fall_o, dm_rise_o, dm_fall_o);
                end
            end else begin
                chk("dq_idle", {dq_rise_o, dq_fall_o, dm_rise_o, dm_fall_o}, 64'(0));
            end
            while (rq.size() > 0 && rq[0].due < cyc) begin
                e = rq.pop_front();
                chk("rd_missing", 64'(cyc), 64'(e.due));
            end
            if (rd_valid) begin
                if (rq.size() == 0) begin
                    chk("rd_unexpected", 64'(1), 64'(0));
                end else begin
                    e = rq.pop_front();
                    chk("rd_due", 64'(cyc), 64'(e.due));
                    chk("rd_data", {rd_data_rise, rd_data_fall}, {e.r, e.f});
                    $display("RD cyc=%0d rise=%h fall=%h", cyc, rd_data_rise, rd_data_fall);
                end
            end
            if (data_idelay_ce[15:8] != '0) ce_hi_cnt++;
            if (data_idelay_ce[7:0] != '0) ce_lo_cnt++;
            for (int l = 0; l < L; l++) begin
                chk("lane_tap", 64'(lane_tap[l*TW +: TW]), 64'(m_tap[l]));
                chk("idly_ctl", {data_idelay_rst[l*DQ +: DQ], data_idelay_ce[l*DQ +: DQ],
                                 data_idelay_inc[l*DQ +: DQ]},
                    {{DQ{m_rst[l]}}, {DQ{m_ce[l]}}, {DQ{m_inc[l]}}});
                cr = dly_rst[l]; cc = dly_ce[l]; ci = dly_inc[l];
                m_rst[l] = cr; m_inc[l] = cc & ci; m_ce[l] = 1'b0;
                if (cr) m_tap[l] = 0;
                else if (cc && ci) begin
                    if (m_tap[l] < TMAX) begin m_tap[l] = m_tap[l] + 1; m_ce[l] = 1'b1; end
                end else if (cc) begin
                    if (m_tap[l] > 0) begin m_tap[l] = m_tap[l] - 1; m_ce[l] = 1'b1; end
                end
            end
        end
    end

    initial begin
        int n;
        reset0 = 1'b1; wr_en = 0; rd_en = 0; lane_lat = '0;
        wr_data_rise = '0; wr_data_fall = '0; mask_data_rise = '0; mask_data_fall = '0;
        rd_dq_rise_i = '0; rd_dq_fall_i = '0; dly_rst = '0; dly_ce = '0; dly_inc = '0;
        for (int i = 0; i < NCYC; i++) begin
            pad_r[i] = DW'($urandom); pad_f[i] = DW'($urandom);
        end
        #23;
        chk("rst_oe", {dq_oe, dqs_oe, wr_busy, rd_valid}, 64'(0));
        chk("rst_dq", {dq_rise_o, dq_fall_o, dm_rise_o, dm_fall_o, dqs_rise_o}, 64'(0));
        chk("rst_rd", {rd_data_rise, rd_data_fall}, 64'(0));
        chk("rst_tap", 64'(lane_tap), 64'(0));
        chk("rst_idly", {data_idelay_rst, data_idelay_ce, data_idelay_inc}, 64'(0));

        // single beat at cycle 10
        rnd_idle(10);
        drive(1'b1, 16'hA5A5, 16'h5A5A, 2'b01, 2'b10, 1'b0, '0, '0, '0);
        rnd_idle(6);

        // burst merge: four beats, one-cycle gap, two beats
        for (int i = 0; i < 7; i++)
            drive(i != 4, DW'($urandom), DW'($urandom), L'($urandom), L'($urandom), 1'b0, '0, '0, '0);
        rnd_idle(6);

        // deskew: lane1 two cycles late
        lane_lat = 4'b1000;
        rnd_idle(8);
        n = cyc + 1;
        pad_r[n][7:0] = 8'h11;
        pad_r[n+2][15:8] = 8'h22;
        drive(1'b0, '0, '0, '0, '0, 1'b1, '0, '0, '0);
        rnd_idle(5);
        chk("deskew_valid", 64'(rd_valid), 64'(1));
        chk("deskew_data", 64'(rd_data_rise), 64'(16'h2211));
        rnd_idle(4);

        // randomized traffic under two latency settings
        for (int k = 0; k < 2; k++) begin
            lane_lat = 4'($urandom);
            rnd_idle(8);
            for (int i = 0; i < 300; i++) rnd_cycle();
            rnd_idle(8);
        end

        // tap saturation on lane 1
        drive(1'b0, '0, '0, '0, '0, 1'b0, 2'b10, '0, '0);
        rnd_idle(2);
        ce_hi_cnt = 0; ce_lo_cnt = 0;
        for (int i = 0; i < 70; i++)
            drive(1'b0, '0, '0, '0, '0, 1'b0, '0, 2'b10, 2'b10);
        rnd_idle(2);
        chk("sat_ce_count", 64'(ce_hi_cnt), 64'(63));
        chk("sat_lane0_ce", 64'(ce_lo_cnt), 64'(0));
        chk("sat_tap", 64'(lane_tap[2*TW-1:TW]), 64'(TMAX));
        drive(1'b0, '0, '0, '0, '0, 1'b0, 2'b10, 2'b10, 2'b10);
        rnd_idle(1);
        chk("rst_pri_tap", 64'(lane_tap[2*TW-1:TW]), 64'(0));
        chk("rst_pri_fwd", {data_idelay_rst[15:8], data_idelay_ce[15:8]}, 64'(16'hFF00));

        // tap floor on lane 0
        drive(1'b0, '0, '0, '0, '0, 1'b0, 2'b01, '0, '0);
        drive(1'b0, '0, '0, '0, '0, 1'b0, '0, 2'b01, 2'b00);
        rnd_idle(1);
        chk("floor_tap", 64'(lane_tap[TW-1:0]), 64'(0));
        chk("floor_ce", 64'(data_idelay_ce[7:0]), 64'(0));

        // asynchronous reset in the middle of a burst
        for (int i = 0; i < 4; i++)
            drive(1'b1, DW'($urandom), DW'($urandom), L'($urandom), L'($urandom), 1'b1, '0, 2'b11, 2'b11);
        chk("pre_rst_oe", {dq_oe, dqs_oe}, 64'(2'b11));
        #2;
        reset0 = 1'b1;
        #1;
        chk("arst_oe", {dq_oe, dqs_oe, rd_valid}, 64'(0));
        chk("arst_tap", 64'(lane_tap), 64'(0));
        hist_base = cyc + 1;
        wq.delete();
        rq.delete();

        // first write after release must show the full preamble
        drive(1'b0, '0, '0, '0, '0, 1'b0, '0, '0, '0);
        drive(1'b1, 16'h1234, 16'h5678, 2'b11, 2'b00, 1'b0, '0, '0, '0);
        rnd_idle(1);
        chk("post_rst_preamble", {dqs_oe, dq_oe}, 64'(2'b10));
        rnd_idle(10);

        chk("wq_empty", 64'(wq.size()), 64'(0));
        chk("rq_empty", 64'(rq.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
